wb_queue: RTL and testbench

- Write-back initiator for the 32x32 register file's single write port (rd, writeEn, data).
- Accepts results from two producers, the ALU and the load unit, and buffers them in an in-order FIFO.
- Drains one entry per cycle onto the register-file write port.
- Gives the decode stage a forwarding lookup against pending entries, so reads of not-yet-written registers return correct data.

---
 rtl/wbq_pkg.sv | 15 +
 rtl/wbq_fwd_match.sv | 32 +++
 rtl/wb_queue.sv | 109 ++++++++++
 tb/tb_wb_queue.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wbq_pkg.sv
// Shared defaults and entry type for the write-back queue.
package wbq_pkg;

    localparam int WBQ_DATA_W = 32;
    localparam int WBQ_ADDR_W = 5;
    localparam int WBQ_DEPTH  = 4;

    // One pending register-file write; valid marks a live slot.
    typedef struct packed {
        logic                  valid;
        logic [WBQ_ADDR_W-1:0] rd;
        logic [WBQ_DATA_W-1:0] data;
    } wbq_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Forwarding CAM: finds the youngest pending entry whose rd matches rs.
module wbq_fwd_match
    import wbq_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH
) (
    input  wbq_entry_t                  entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]    head,
    input  logic [$clog2(DEPTH):0]      count,
    input  logic [WBQ_ADDR_W-1:0]       rs,
    output logic                        hit,
    output logic [WBQ_DATA_W-1:0]       data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Walk oldest to youngest from head; later matches overwrite earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && (rs != '0) &&
                entries[head + PW'(i)].valid &&
                (entries[head + PW'(i)].rd == rs)) begin
                hit  = 1'b1;
                data = entries[head + PW'(i)].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: merges ALU and load results into an in-order FIFO,
// drains one entry per cycle to the register file, and forwards pending
// data to decode. Entry widths follow the wbq_pkg defaults.
module wb_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH  = WBQ_DEPTH,
    parameter int DATA_W = WBQ_DATA_W,
    parameter int ADDR_W = WBQ_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_rd,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     ld_ready,
    output logic                     rf_writeEn,
    output logic [ADDR_W-1:0]        rf_rd,
    output logic [DATA_W-1:0]        rf_data,
    input  logic [ADDR_W-1:0]        rs1,
    input  logic [ADDR_W-1:0]        rs2,
    output logic                     fwd1_hit,
    output logic [DATA_W-1:0]        fwd1_data,
    output logic                     fwd2_hit,
    output logic [DATA_W-1:0]        fwd2_data,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbq_entry_t       entries [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic             pop;
    logic             ld_enq;
    logic             alu_enq;
    logic [1:0]       enq_count;
    wbq_entry_t       head_e;

    // Readiness looks only at the registered count; load keeps the last slot.
    always_comb begin
        ld_ready  = (count < CW'(DEPTH));
        alu_ready = ld_valid ? (count <= CW'(DEPTH - 2)) : (count < CW'(DEPTH));
        ld_enq    = ld_valid && ld_ready && (ld_rd != '0);
        alu_enq   = alu_valid && alu_ready && (alu_rd != '0);
        enq_count = {1'b0, ld_enq} + {1'b0, alu_enq};
        pop       = (count != '0);
        head_e    = entries[head];
    end

    // Write port shows the head; reset suppresses it so queued data never lands.
    always_comb begin
        rf_writeEn = pop && head_e.valid && !reset;
        rf_rd      = rf_writeEn ? head_e.rd   : '0;
        rf_data    = rf_writeEn ? head_e.data : '0;
        pending    = count;
    end

    // FIFO storage and pointers; load is enqueued ahead of a same-cycle ALU result.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (pop) begin
                entries[head].valid <= 1'b0;
            end
            if (ld_enq) begin
                entries[tail] <= '{valid: 1'b1, rd: ld_rd, data: ld_data};
            end
            if (alu_enq) begin
                entries[tail + PW'(ld_enq)] <= '{valid: 1'b1, rd: alu_rd, data: alu_data};
            end
            head  <= head + PW'(pop);
            tail  <= tail + PW'(enq_count);
            count <= count + CW'(enq_count) - CW'(pop);
        end
    end

    wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (entries),
        .head    (head),
        .count   (count),
        .rs      (rs1),
        .hit     (fwd1_hit),
        .data    (fwd1_data)
    );

    wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (entries),
        .head    (head),
        .count   (count),
        .rs      (rs2),
        .hit     (fwd2_hit),
        .data    (fwd2_data)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue with DEPTH=4.
module tb_wb_queue;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        rf_writeEn;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fwd1_hit;
    logic [31:0] fwd1_data;
    logic        fwd2_hit;
    logic [31:0] fwd2_data;
    logic [2:0]  pending;

    int checks   = 0;
    int failures = 0;

    wb_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .rf_writeEn (rf_writeEn),
        .rf_rd      (rf_rd),
        .rf_data    (rf_data),
        .rs1        (rs1),
        .rs2        (rs2),
        .fwd1_hit   (fwd1_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_hit   (fwd2_hit),
        .fwd2_data  (fwd2_data),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        rs1 = 5'd5;
        rs2 = 5'd3;
        #1;
        checks++; if (rf_writeEn !== 1'b0) begin failures++; $display("FAIL reset_wen got=%0b exp=0", rf_writeEn); end
        checks++; if (rf_rd !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", rf_rd); end
        checks++; if (rf_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", rf_data); end
        checks++; if (pending !== 3'd0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending); end
        checks++; if (fwd1_hit !== 1'b0 || fwd1_data !== 32'd0) begin failures++; $display("FAIL reset_fwd1 got=%0b/%0h exp=0/0", fwd1_hit, fwd1_data); end
        checks++; if (fwd2_hit !== 1'b0 || fwd2_data !== 32'd0) begin failures++; $display("FAIL reset_fwd2 got=%0b/%0h exp=0/0", fwd2_hit, fwd2_data); end
        reset = 1'b0;
        #1;
        checks++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b/%0b exp=1/1", ld_ready, alu_ready); end
    endtask

    task automatic test_single();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%0b exp=1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        rs1 = 5'd5;
        #1;
        checks++; if (rf_writeEn !== 1'b1) begin failures++; $display("FAIL single_wen got=%0b exp=1", rf_writeEn); end
        checks++; if (rf_rd !== 5'd5) begin failures++; $display("FAIL single_rd got=%0d exp=5", rf_rd); end
        checks++; if (rf_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%0h exp=deadbeef", rf_data); end
        checks++; if (pending !== 3'd1) begin failures++; $display("FAIL single_pending got=%0d exp=1", pending); end
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_fwd_head got=%0b/%0h exp=1/deadbeef", fwd1_hit, fwd1_data); end
        tick();
        checks++; if (rf_writeEn !== 1'b0) begin failures++; $display("FAIL single_wen_after got=%0b exp=0", rf_writeEn); end
        checks++; if (pending !== 3'd0) begin failures++; $display("FAIL single_pending_after got=%0d exp=0", pending); end
        checks++; if (fwd1_hit !== 1'b0) begin failures++; $display("FAIL single_fwd_after got=%0b exp=0", fwd1_hit); end
    endtask

    task automatic test_dual();
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
        #1;
        checks++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin failures++; $display("FAIL dual_ready got=%0b/%0b exp=1/1", ld_ready, alu_ready); end
        tick();
        ld_valid = 1'b0; alu_valid = 1'b0;
        #1;
        checks++; if (pending !== 3'd2) begin failures++; $display("FAIL dual_pending0 got=%0d exp=2", pending); end
        checks++; if (rf_writeEn !== 1'b1 || rf_rd !== 5'd3 || rf_data !== 32'h11) begin failures++; $display("FAIL dual_first got=%0b/%0d/%0h exp=1/3/11", rf_writeEn, rf_rd, rf_data); end
        tick();
        checks++; if (pending !== 3'd1) begin failures++; $display("FAIL dual_pending1 got=%0d exp=1", pending); end
        checks++; if (rf_writeEn !== 1'b1 || rf_rd !== 5'd4 || rf_data !== 32'h22) begin failures++; $display("FAIL dual_second got=%0b/%0d/%0h exp=1/4/22", rf_writeEn, rf_rd, rf_data); end
        tick();
        checks++; if (pending !== 3'd0 || rf_writeEn !== 1'b0) begin failures++; $display("FAIL dual_empty got=%0d/%0b exp=0/0", pending, rf_writeEn); end
    endtask

    task automatic test_fwd_youngest();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1;
        tick();
        alu_data = 32'h2;
        rs1 = 5'd7; rs2 = 5'd0;
        #1;
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h1) begin failures++; $display("FAIL fwd_same_cycle got=%0b/%0h exp=1/1", fwd1_hit, fwd1_data); end
        tick();
        alu_valid = 1'b0;
        #1;
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h2) begin failures++; $display("FAIL fwd_b2b got=%0b/%0h exp=1/2", fwd1_hit, fwd1_data); end
        checks++; if (fwd2_hit !== 1'b0 || fwd2_data !== 32'h0) begin failures++; $display("FAIL fwd_x0 got=%0b/%0h exp=0/0", fwd2_hit, fwd2_data); end
        tick();
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'hA;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hB;
        tick();
        ld_valid = 1'b0; alu_valid = 1'b0;
        rs1 = 5'd9; rs2 = 5'd9;
        #1;
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'hB) begin failures++; $display("FAIL fwd_youngest got=%0b/%0h exp=1/b", fwd1_hit, fwd1_data); end
        checks++; if (rf_rd !== 5'd9 || rf_data !== 32'hA || pending !== 3'd2) begin failures++; $display("FAIL fwd_head got=%0d/%0h/%0d exp=9/a/2", rf_rd, rf_data, pending); end
        tick();
        tick();
        checks++; if (pending !== 3'd0 || fwd2_hit !== 1'b0) begin failures++; $display("FAIL fwd_drained got=%0d/%0b exp=0/0", pending, fwd2_hit); end
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL x0_ready cyc=%0d got=%0b exp=1", c, alu_ready); end
            checks++; if (pending !== 3'd0) begin failures++; $display("FAIL x0_pending cyc=%0d got=%0d exp=0", c, pending); end
            checks++; if (rf_writeEn !== 1'b0) begin failures++; $display("FAIL x0_wen cyc=%0d got=%0b exp=0", c, rf_writeEn); end
            tick();
        end
        alu_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_rd [$];
        logic [31:0] exp_data [$];
        int exp_alu_rdy [6] = '{1, 1, 0, 0, 0, 0};
        int exp_pend    [6] = '{0, 2, 3, 3, 3, 3};
        int ld_k  = 0;
        int alu_k = 0;
        for (int c = 0; c < 6; c++) begin
            ld_valid = 1'b1; ld_rd = 5'(1 + ld_k); ld_data = 32'h100 + 32'(ld_k);
            alu_valid = 1'b1; alu_rd = 5'(17 + alu_k); alu_data = 32'h200 + 32'(alu_k);
            #1;
            checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL b2b_ld_ready cyc=%0d got=%0b exp=1", c, ld_ready); end
            checks++; if (alu_ready !== 1'(exp_alu_rdy[c])) begin failures++; $display("FAIL b2b_alu_ready cyc=%0d got=%0b exp=%0d", c, alu_ready, exp_alu_rdy[c]); end
            checks++; if (pending !== 3'(exp_pend[c])) begin failures++; $display("FAIL b2b_pending cyc=%0d got=%0d exp=%0d", c, pending, exp_pend[c]); end
            if (rf_writeEn === 1'b1) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    failures++; $display("FAIL b2b_write cyc=%0d got=%0d/%0h exp=none", c, rf_rd, rf_data);
                end else begin
                    if (rf_rd !== exp_rd[0] || rf_data !== exp_data[0]) begin
                        failures++; $display("FAIL b2b_write cyc=%0d got=%0d/%0h exp=%0d/%0h", c, rf_rd, rf_data, exp_rd[0], exp_data[0]);
                    end
                    void'(exp_rd.pop_front()); void'(exp_data.pop_front());
                end
            end
            exp_rd.push_back(ld_rd); exp_data.push_back(ld_data); ld_k++;
            if (exp_alu_rdy[c] == 1) begin
                exp_rd.push_back(alu_rd); exp_data.push_back(alu_data); alu_k++;
            end
            tick();
        end
        ld_valid = 1'b0; alu_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (rf_writeEn === 1'b1) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    failures++; $display("FAIL drain_write got=%0d/%0h exp=none", rf_rd, rf_data);
                end else begin
                    if (rf_rd !== exp_rd[0] || rf_data !== exp_data[0]) begin
                        failures++; $display("FAIL drain_write got=%0d/%0h exp=%0d/%0h", rf_rd, rf_data, exp_rd[0], exp_data[0]);
                    end
                    void'(exp_rd.pop_front()); void'(exp_data.pop_front());
                end
            end
            if (pending === 3'd0) break;
            tick();
        end
        checks++; if (pending !== 3'd0) begin failures++; $display("FAIL drain_timeout pending got=%0d exp=0", pending); end
        checks++; if (exp_rd.size() != 0) begin failures++; $display("FAIL drain_lost got=%0d exp=0 entries outstanding", exp_rd.size()); end
    endtask

    task automatic test_reset_mid();
        ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'h10;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h11;
        tick();
        ld_rd = 5'd12; ld_data = 32'h12;
        alu_rd = 5'd13; alu_data = 32'h13;
        tick();
        ld_valid = 1'b0; alu_valid = 1'b0;
        #1;
        checks++; if (pending !== 3'd3) begin failures++; $display("FAIL rmid_pre_pending got=%0d exp=3", pending); end
        reset = 1'b1;
        #1;
        checks++; if (rf_writeEn !== 1'b0) begin failures++; $display("FAIL rmid_wen_in_reset got=%0b exp=0", rf_writeEn); end
        tick();
        reset = 1'b0;
        rs1 = 5'd12; rs2 = 5'd13;
        #1;
        checks++; if (rf_writeEn !== 1'b0 || pending !== 3'd0) begin failures++; $display("FAIL rmid_after got=%0b/%0d exp=0/0", rf_writeEn, pending); end
        checks++; if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin failures++; $display("FAIL rmid_fwd got=%0b/%0b exp=0/0", fwd1_hit, fwd2_hit); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (rf_writeEn !== 1'b0) begin failures++; $display("FAIL rmid_stale_write cyc=%0d got=%0b/%0d exp=0", c, rf_writeEn, rf_rd); end
        end
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        rs1 = '0; rs2 = '0;
        test_reset();
        test_single();
        test_dual();
        test_fwd_youngest();
        test_x0();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
